tdm_demux_8ch: RTL
==================

Name: tdm_demux_8ch

Overview:
- Receive end of the team's 8-to-1 channel multiplexing scheme.
- Accepts a time-division-multiplexed sample stream (one channel sample per valid beat, channel 0 marked by a start-of-frame flag).
- Routes each sample to its channel slot and presents all 8 channels in parallel once per complete frame.
- Detects framing loss and resynchronises on the next start-of-frame.

Parameters:
- W, 1, width in bits of one channel sample.
- CH, 8, number of channels; fixed at 8, slot counter is 3 bits.

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  serial-slot sample for the current channel.
- din_valid  input  1  din carries a sample this cycle.
- sof  input  1  start of frame; qualified by din_valid; marks the channel 0 sample.
- dout  output  CH*W  parallel frame; channel k occupies bits [k*W +: W], so channel 0 is the LSBs.
- frame_valid  output  1  one-cycle pulse when dout updates.
- sync_err  output  1  one-cycle pulse on a framing violation.
- slot  output  3  index of the channel the next accepted beat is written to.
- locked  output  1  high in RUN state.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync-released use on next clk edge):
  - dout = 0, frame_valid = 0, sync_err = 0, slot = 0, frame_cnt = 0, state = IDLE.
  - The internal shadow register is cleared.
  - Reset mid-frame discards the partial frame; dout is not updated.
- States: IDLE, RUN. locked = (state == RUN).
- IDLE:
  - Beats with din_valid=1 and sof=0 are dropped silently; no sync_err.
  - din_valid=1 with sof=1 writes din to shadow[0], sets slot=1 and moves to RUN.
  - sof with din_valid=0 is ignored in all states.
- RUN, beat accepted (din_valid=1):
  - slot 1..6, sof=0: shadow[slot] <= din; slot <= slot+1.
  - slot 7, sof=0: dout <= {din, shadow[6:0]} (channel 7 taken directly from din). Then, on the next edge:
    - frame_valid = 1 for exactly one cycle;
    - frame_cnt increments;
    - slot wraps to 0;
    - stay RUN.
  - Latency: frame_valid and the new dout are visible on the cycle after the slot-7 beat is accepted.
  - slot 0, sof=1: normal frame start; shadow[0] <= din; slot <= 1.
  - slot 0, sof=0: sync_err pulse; beat dropped; slot = 0; move to IDLE.
  - slot 1..7, sof=1: sync_err pulse; partial frame discarded (no frame_valid, dout unchanged); beat taken as the new channel 0; slot <= 1; stay RUN (resync).
- din_valid=0 in any state: no state change; slot holds; gaps between beats of any length are allowed.
- dout holds its value between frames; it changes only together with frame_valid.
- frame_valid and sync_err are never asserted in the same cycle. The slot-7 beat with sof=1 is a resync case, not a completion.
- Back-to-back frames: a sof beat in the cycle frame_valid is high is legal and starts the next frame with no bubble.

Test Plan:
- Reset then one frame, W=1, beats ch0..ch7 = 1,0,1,1,0,0,1,1 with sof on the first beat and din_valid continuous:
  - frame_valid pulses once, 1 cycle after the 8th beat;
  - dout = 8'b11001101;
  - frame_cnt = 1; locked = 1 throughout.
- Same frame with din_valid deasserted for 3 cycles between slots 3 and 4:
  - identical dout = 8'b11001101;
  - slot reads 4 during the gap;
  - no sync_err.
- Two back-to-back frames, the second 8'b00110010:
  - two frame_valid pulses 8 cycles apart;
  - dout 8'b11001101 then 8'b00110010;
  - frame_cnt = 2.
- Resync: sof=1 asserted on the slot-5 beat:
  - sync_err pulses once; no frame_valid; dout unchanged;
  - the following 7 beats complete a frame aligned to the new sof.
- Missing sof at slot 0 after a good frame:
  - sync_err pulse; locked drops to 0;
  - subsequent non-sof beats are ignored, with no further sync_err;
  - the next sof beat relocks.
- Assert rst_n=0 asynchronously after slot 4 of a frame:
  - all outputs return to reset values immediately, without waiting for clk;
  - after release, a full frame decodes correctly with frame_cnt = 1.

Source files
------------

// File: rtl/tdm_demux_8ch.sv
// Receive side of the 8-channel TDM link: collects one sample per valid beat
// into a shadow register and publishes the whole frame when channel 7 arrives.
module tdm_demux_8ch #(
  parameter int W  = 1,
  parameter int CH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [CH*W-1:0]   dout,
  output logic              frame_valid,
  output logic              sync_err,
  output logic [2:0]        slot,
  output logic              locked,
  output logic [7:0]        frame_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] LAST = 3'(CH - 1);

  state_t                state;
  logic [(CH-1)*W-1:0]   shadow;

  assign locked = (state == RUN);

  // Channel 7 bypasses the shadow so the frame is published one cycle after its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      slot        <= 3'd0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            if (sof) begin
              shadow[W-1:0] <= din;
              slot          <= 3'd1;
              state         <= RUN;
            end
          end
          RUN: begin
            if (sof) begin
              sync_err      <= (slot != 3'd0);
              shadow[W-1:0] <= din;
              slot          <= 3'd1;
            end else if (slot == 3'd0) begin
              sync_err <= 1'b1;
              state    <= IDLE;
            end else if (slot == LAST) begin
              dout        <= {din, shadow};
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
              slot        <= 3'd0;
            end else begin
              shadow[int'(slot)*W +: W] <= din;
              slot                      <= slot + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
